lookup_table_controller: RTL and testbench

Sequencer that shares one lookup table between lookup traffic and reloads of the table contents. It sits between the modem's symbol/address stream and the table's lookup port, and between the configuration stream and the table's load port. Before a reload it blocks lookups at a packet boundary and drains the table's output pipeline. It then streams exactly `TABLE_DEPTH` words into the table with a correctly placed `tlast`, and resumes lookups afterwards.

---
 rtl/lookup_table_controller.sv | 121 ++++++++++++
 tb/tb_lookup_table_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lookup_table_controller.sv
// lookup_table_controller: shares one lookup table between lookup traffic and table reloads.
// Optional LUT_CTRL_BLOCK_UNLOADED_EN stalls lookups until the first complete load.
module lookup_table_controller #(
  parameter int TDATA_WIDTH   = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int TABLE_DEPTH   = 256,
  parameter int DRAIN_CYCLES  = 2
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  output logic                     s_lookup_tready,
  input  logic [ADDRESS_WIDTH-1:0] s_lookup_tdata,
  input  logic                     s_lookup_tlast,
  input  logic                     s_lookup_tvalid,
  input  logic                     m_lookup_tready,
  output logic [ADDRESS_WIDTH-1:0] m_lookup_tdata,
  output logic                     m_lookup_tlast,
  output logic                     m_lookup_tvalid,
  output logic                     s_load_tready,
  input  logic [TDATA_WIDTH-1:0]   s_load_tdata,
  input  logic                     s_load_tlast,
  input  logic                     s_load_tvalid,
  input  logic                     m_load_tready,
  output logic [TDATA_WIDTH-1:0]   m_load_tdata,
  output logic                     m_load_tlast,
  output logic                     m_load_tvalid,
  output logic                     table_valid,
  output logic                     load_error,
  output logic [ADDRESS_WIDTH:0]   load_count
);
  typedef enum logic [2:0] {IDLE, DRAIN, LOAD, FLUSH, DONE} state_t;
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDRESS_WIDTH:0] LAST = (ADDRESS_WIDTH+1)'(TABLE_DEPTH - 1);
  localparam logic [DW-1:0] DRAIN_END = DW'(DRAIN_CYCLES - 1);
  state_t state_q, state_d;
  logic in_packet_q, in_packet_d, table_valid_q, table_valid_d;
  logic load_error_q, load_error_d, short_q, short_d;
  logic [ADDRESS_WIDTH:0] load_count_q, load_count_d;
  logic [DW-1:0] drain_q, drain_d;
  logic gate, lk_pass, ld_pass, lk_acc, ld_acc, at_last;
`ifdef LUT_CTRL_BLOCK_UNLOADED_EN
  assign gate = table_valid_q;
`else
  assign gate = 1'b1;
`endif
  assign table_valid = table_valid_q;
  assign load_error  = load_error_q;
  assign load_count  = load_count_q;
  // Handshake outputs are forced low while aresetn is asserted so reset values hold immediately.
  always_comb begin
    lk_pass = aresetn && state_q == IDLE && gate;
    ld_pass = aresetn && state_q == LOAD;
    m_lookup_tvalid = lk_pass & s_lookup_tvalid;
    s_lookup_tready = lk_pass & m_lookup_tready;
    m_lookup_tdata = s_lookup_tdata;
    m_lookup_tlast = s_lookup_tlast;
    m_load_tvalid = ld_pass & s_load_tvalid;
    s_load_tready = ld_pass ? m_load_tready : (aresetn && state_q == FLUSH);
    m_load_tdata = s_load_tdata;
    at_last = load_count_q == LAST;
    m_load_tlast = at_last | s_load_tlast;
    lk_acc = m_lookup_tvalid & m_lookup_tready;
    ld_acc = s_load_tvalid & s_load_tready;
    state_d = state_q;
    in_packet_d = lk_acc ? !s_lookup_tlast : in_packet_q;
    drain_d = '0;
    load_count_d = load_count_q;
    load_error_d = load_error_q;
    table_valid_d = table_valid_q;
    short_d = short_q;
    case (state_q)
      // Leave only between packets and never while a lookup beat is stalled mid-handshake.
      IDLE: if (s_load_tvalid && ((!in_packet_q && !(m_lookup_tvalid && !m_lookup_tready)) || (lk_acc && s_lookup_tlast)))
        state_d = DRAIN;
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_END) begin
          state_d = LOAD;
          load_count_d = '0;
          load_error_d = 1'b0;
          short_d = 1'b0;
        end
      end
      LOAD: if (ld_acc) begin
        load_count_d = load_count_q + 1'b1;
        if (at_last) begin
          state_d = s_load_tlast ? DONE : FLUSH;
          load_error_d = !s_load_tlast;
        end else if (s_load_tlast) begin
          state_d = DONE;
          load_error_d = 1'b1;
          short_d = 1'b1;
        end
      end
      FLUSH: if (ld_acc && s_load_tlast) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        table_valid_d = table_valid_q | !short_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q <= IDLE;
      in_packet_q <= 1'b0;
      table_valid_q <= 1'b0;
      load_error_q <= 1'b0;
      short_q <= 1'b0;
      load_count_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      in_packet_q <= in_packet_d;
      table_valid_q <= table_valid_d;
      load_error_q <= load_error_d;
      short_q <= short_d;
      load_count_q <= load_count_d;
      drain_q <= drain_d;
    end
endmodule

// File: tb/tb_lookup_table_controller.sv
// tb_lookup_table_controller: vector table, directed load sequences and randomized traffic
// checked against a transaction-level model of the lookup/load sequencer.
`timescale 1ns/1ps
module tb_lookup_table_controller;
  localparam int TW = 32, AW = 8, DEPTH = 256, DRAIN = 2;
`ifdef LUT_CTRL_BLOCK_UNLOADED_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif
  localparam bit P = !BLK;
  logic aclk = 0, aresetn = 0;
  logic s_lookup_tready, s_lookup_tlast = 0, s_lookup_tvalid = 0;
  logic [AW-1:0] s_lookup_tdata = '0, m_lookup_tdata;
  logic m_lookup_tready = 0, m_lookup_tlast, m_lookup_tvalid;
  logic s_load_tready, s_load_tlast = 0, s_load_tvalid = 0;
  logic [TW-1:0] s_load_tdata = '0, m_load_tdata;
  logic m_load_tready = 0, m_load_tlast, m_load_tvalid;
  logic table_valid, load_error;
  logic [AW:0] load_count;
  int errors = 0, checks = 0;
  bit tv = 0;
  logic [TW-1:0] qd[$];
  logic ql[$];
  typedef struct {
    logic sv; logic [AW-1:0] sd; logic sl; logic mr;
    logic mv; logic [AW-1:0] md; logic ml; logic sr;
  } vec_t;
  vec_t vecs[10];

  always #5 aclk = ~aclk;

  lookup_table_controller #(.TDATA_WIDTH(TW), .ADDRESS_WIDTH(AW), .TABLE_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_lookup_tready(s_lookup_tready), .s_lookup_tdata(s_lookup_tdata), .s_lookup_tlast(s_lookup_tlast), .s_lookup_tvalid(s_lookup_tvalid),
    .m_lookup_tready(m_lookup_tready), .m_lookup_tdata(m_lookup_tdata), .m_lookup_tlast(m_lookup_tlast), .m_lookup_tvalid(m_lookup_tvalid),
    .s_load_tready(s_load_tready), .s_load_tdata(s_load_tdata), .s_load_tlast(s_load_tlast), .s_load_tvalid(s_load_tvalid),
    .m_load_tready(m_load_tready), .m_load_tdata(m_load_tdata), .m_load_tlast(m_load_tlast), .m_load_tvalid(m_load_tvalid),
    .table_valid(table_valid), .load_error(load_error), .load_count(load_count)
  );

  always @(negedge aclk)
    if (m_load_tvalid && m_load_tready) begin
      qd.push_back(m_load_tdata);
      ql.push_back(m_load_tlast);
    end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic bit g();
    return !BLK || tv;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Streams n words base..base+n-1 (tlast on the last); stops early after `stop` accepted words.
  task automatic run_load(input int n, input int stop, input int base, input bit measure, input bit rnd);
    int i, cyc, waits, exp_fwd, bad;
    bit hold;
    i = 0; cyc = 0; waits = 0; bad = 0; hold = 0;
    qd.delete(); ql.delete();
    m_lookup_tready = 1;
    while (i < stop && cyc < 4000) begin
      s_load_tdata = TW'(base + i);
      s_load_tlast = (i == n - 1);
      if (!hold) s_load_tvalid = (rnd && i > 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_load_tready = (rnd && i > 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      hold = s_load_tvalid && !s_load_tready;
      if (s_load_tvalid && s_load_tready) i++;
      else if (i == 0) waits++;
      cyc++;
      tick();
    end
    check("load_words_accepted", i, stop);
    if (measure) check("req_to_first_beat", waits, 1 + DRAIN);
    if (stop < n) return;
    s_load_tvalid = 0;
    s_load_tlast = 0;
    exp_fwd = n < DEPTH ? n : DEPTH;
    if (n >= DEPTH) tv = 1;
    #1;
    check("lookup_blocked_in_done", s_lookup_tready, 0);
    tick();
    check("lookup_resumed", s_lookup_tready, g());
    check("fwd_count", qd.size(), exp_fwd);
    for (int k = 0; k < qd.size(); k++)
      if (qd[k] !== TW'(base + k) || ql[k] !== (k == exp_fwd - 1)) bad++;
    check("fwd_beats_bad", bad, 0);
    check("load_count", load_count, exp_fwd);
    check("load_error", load_error, n != DEPTH);
    check("table_valid", table_valid, tv);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b1, P, 8'h01, 1'b0, P};
    vecs[1] = '{1'b1, 8'h02, 1'b0, 1'b0, P, 8'h02, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h02, 1'b0, 1'b1, P, 8'h02, 1'b0, P};
    vecs[3] = '{1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, P};
    vecs[4] = '{1'b1, 8'h03, 1'b1, 1'b1, P, 8'h03, 1'b1, P};
    vecs[5] = '{1'b1, 8'hff, 1'b0, 1'b1, P, 8'hff, 1'b0, P};
    vecs[6] = '{1'b1, 8'h00, 1'b0, 1'b1, P, 8'h00, 1'b0, P};
    vecs[7] = '{1'b0, 8'haa, 1'b1, 1'b0, 1'b0, 8'haa, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 8'h7e, 1'b0, 1'b1, P, 8'h7e, 1'b0, P};
    vecs[9] = '{1'b1, 8'h80, 1'b1, 1'b1, P, 8'h80, 1'b1, P};

    // Reset values with every upstream valid/ready pushing high
    s_lookup_tvalid = 1; m_lookup_tready = 1; s_load_tvalid = 1; m_load_tready = 1;
    #12;
    check("rst_s_lookup_tready", s_lookup_tready, 0);
    check("rst_m_lookup_tvalid", m_lookup_tvalid, 0);
    check("rst_s_load_tready", s_load_tready, 0);
    check("rst_m_load_tvalid", m_load_tvalid, 0);
    check("rst_table_valid", table_valid, 0);
    check("rst_load_error", load_error, 0);
    check("rst_load_count", load_count, 0);
    s_lookup_tvalid = 0; s_load_tvalid = 0; m_load_tready = 0;
    @(negedge aclk);
    aresetn = 1;
    tick();

    // Lookup pass-through vectors before any load
    for (int i = 0; i < 10; i++) begin
      s_lookup_tvalid = vecs[i].sv; s_lookup_tdata = vecs[i].sd;
      s_lookup_tlast = vecs[i].sl; m_lookup_tready = vecs[i].mr;
      #1;
      check($sformatf("vec%0d", i), {m_lookup_tvalid, m_lookup_tdata, m_lookup_tlast, s_lookup_tready},
            {vecs[i].mv, vecs[i].md, vecs[i].ml, vecs[i].sr});
      check($sformatf("vec%0d_load_blocked", i), {m_load_tvalid, s_load_tready}, 0);
      tick();
    end
    s_lookup_tvalid = 0; s_lookup_tlast = 0;

    // Full load 0..255 with latency measurement
    run_load(256, 256, 0, 1, 0);

    // Randomized lookup traffic in IDLE
    for (int c = 0; c < 150; c++) begin
      s_lookup_tvalid = 1'($urandom_range(0, 1));
      s_lookup_tdata = AW'($urandom);
      s_lookup_tlast = 1'($urandom_range(0, 1));
      m_lookup_tready = 1'($urandom_range(0, 1));
      #1;
      check("rnd_m_valid", m_lookup_tvalid, s_lookup_tvalid & g());
      check("rnd_s_ready", s_lookup_tready, m_lookup_tready & g());
      if (m_lookup_tvalid) check("rnd_data", {m_lookup_tdata, m_lookup_tlast}, {s_lookup_tdata, s_lookup_tlast});
      check("rnd_load_blocked", {m_load_tvalid, s_load_tready}, 0);
      tick();
    end
    s_lookup_tvalid = 1; s_lookup_tlast = 1; m_lookup_tready = 1;
    #1;
    check("close_packet", s_lookup_tready, 1);
    tick();
    s_lookup_tvalid = 0; s_lookup_tlast = 0;

    // Load request arrives at beat 3 of an 8-beat packet
    m_load_tready = 1;
    for (int b = 0; b < 8; b++) begin
      s_lookup_tvalid = 1; s_lookup_tdata = AW'(8'h40 + b); s_lookup_tlast = (b == 7);
      if (b == 2) begin s_load_tvalid = 1; s_load_tdata = 1000; s_load_tlast = 0; end
      #1;
      check($sformatf("mid_beat%0d", b), {m_lookup_tvalid, s_lookup_tready, m_lookup_tdata}, {1'b1, 1'b1, AW'(8'h40 + b)});
      tick();
    end
    s_lookup_tvalid = 0; s_lookup_tlast = 0;
    for (int d = 0; d < DRAIN; d++) begin
      #1;
      check($sformatf("drain%0d", d), {s_lookup_tready, s_load_tready, m_load_tvalid}, 0);
      tick();
    end
    #1;
    check("load_after_drain", s_load_tready, 1);
    run_load(256, 256, 1000, 0, 1);

    // Short and long loads with random stalls
    run_load(100, 100, 5000, 0, 1);
    run_load(300, 300, 7000, 0, 1);

    // Reset mid-load at word 50
    run_load(256, 50, 9000, 0, 0);
    check("abort_fwd_count", qd.size(), 50);
    aresetn = 0;
    #1;
    check("abort_m_load_tvalid", m_load_tvalid, 0);
    check("abort_s_load_tready", s_load_tready, 0);
    check("abort_s_lookup_tready", s_lookup_tready, 0);
    check("abort_table_valid", table_valid, 0);
    check("abort_load_count", load_count, 0);
    check("abort_load_error", load_error, 0);
    s_load_tvalid = 0; s_load_tlast = 0;
    tv = 0;
    @(negedge aclk);
    aresetn = 1;
    tick();
    #1;
    check("post_abort_lookup", s_lookup_tready, g());
    run_load(256, 256, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
